// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - request/serial-line bundle between a UART transmitter and its client
interface uart_tx_if #(
  parameter int dataWidth = 8
) ();
  logic                 TXvalid;
  logic [dataWidth-1:0] TXin;
  logic                 TXready;
  logic                 dataOut;
  logic                 TXdone;

  modport master (
    output TXvalid, TXin,
    input  TXready, dataOut, TXdone
  );

  modport slave (
    input  TXvalid, TXin,
    output TXready, dataOut, TXdone
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first payload, optional even parity, 1 or 2 stop bits
module uart_tx #(
  parameter int CLK_PER_BIT = 50,
  parameter int dataWidth   = 8,
  parameter int stopBits    = 2,
  parameter int parityBits  = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave io_tx
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int IW = (dataWidth > 0) ? $clog2(dataWidth + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(dataWidth - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(stopBits - 1);

  if (stopBits != 1 && stopBits != 2) begin : g_bad_stop_bits
    $error("uart_tx: stopBits must be 1 or 2");
  end
  if (parityBits != 0 && parityBits != 1) begin : g_bad_parity_bits
    $error("uart_tx: parityBits must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [dataWidth-1:0] r_data;
  logic                 r_parity;
  logic                 r_line;
  logic                 r_ready;
  logic                 r_done;
  logic                 w_bit_end;

  assign w_bit_end     = (r_cnt == CNT_LAST);
  assign io_tx.dataOut = r_line;
  assign io_tx.TXready = r_ready;
  assign io_tx.TXdone  = r_done;

  // r_data is a shift register: bit 0 is always the next payload bit to go out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_data   <= '0;
      r_parity <= 1'b0;
      r_line   <= 1'b1;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_line <= 1'b1;
          r_cnt  <= '0;
          r_idx  <= '0;
          // ready is held low for the first cycle out of reset, so no accept then
          if (r_ready && io_tx.TXvalid) begin
            r_data   <= io_tx.TXin;
            r_parity <= ^io_tx.TXin;
            r_line   <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= S_START;
          end else begin
            r_ready <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_line  <= r_data[0];
            r_data  <= r_data >> 1;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == DATA_LAST) begin
              r_idx <= '0;
              if (parityBits == 1) begin
                r_line  <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_line  <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_idx  <= r_idx + 1'b1;
              r_line <= r_data[0];
              r_data <= r_data >> 1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_line  <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_STOP: begin
          r_line <= 1'b1;
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == STOP_LAST) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_idx   <= '0;
          r_line  <= 1'b1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed frame vectors and corner sequences for uart_tx
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.dataWidth(8)) a_if ();
  uart_tx_if #(.dataWidth(8)) b_if ();

  uart_tx #(.CLK_PER_BIT(50), .dataWidth(8), .stopBits(2), .parityBits(1)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .io_tx (a_if.slave)
  );

  uart_tx #(.CLK_PER_BIT(50), .dataWidth(8), .stopBits(1), .parityBits(0)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .io_tx (b_if.slave)
  );

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  vec_t vecs[9];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic line_of(input int s);
    return (s != 0) ? b_if.dataOut : a_if.dataOut;
  endfunction
  function automatic logic rdy_of(input int s);
    return (s != 0) ? b_if.TXready : a_if.TXready;
  endfunction
  function automatic logic done_of(input int s);
    return (s != 0) ? b_if.TXdone : a_if.TXdone;
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    if (s != 0) begin b_if.TXvalid = v; b_if.TXin = d; end
    else        begin a_if.TXvalid = v; a_if.TXin = d; end
  endtask

  task automatic wait_ready(input int s, input string nm);
    int n = 0;
    @(negedge clk);
    while (!rdy_of(s) && n < 2000) begin @(negedge clk); n++; end
    check({nm, "_ready_wait"}, 32'(rdy_of(s)), 32'd1);
  endtask

  // One frame; TXvalid/TXin are churned mid-frame and must be ignored.
  task automatic send_frame(input int s, input logic [7:0] d, input int nbits,
                            input logic [11:0] exp, input string nm);
    logic [11:0] got;
    logic [7:0]  cur;
    bit          stable, rdy_bad;
    int          done_at, last;
    got = '0; stable = 1'b1; rdy_bad = 1'b0; done_at = -1; last = nbits * 50;
    wait_ready(s, nm);
    drive(s, 1'b1, d);
    @(posedge clk); #1;
    cur = 8'($urandom);
    drive(s, 1'b0, cur);
    for (int i = 0; i <= last + 5; i++) begin
      @(negedge clk);
      if (i >= 100 && i < 200) begin cur = 8'($urandom); drive(s, 1'b1, cur); end
      else drive(s, 1'b0, cur);
      if (done_of(s)) done_at = (done_at < 0) ? i : -2;
      if (i < last) begin
        if (line_of(s) !== exp[i / 50]) stable = 1'b0;
        if (i % 50 == 25) got[i / 50] = line_of(s);
        if (rdy_of(s)) rdy_bad = 1'b1;
      end
    end
    check({nm, "_bits"},    32'(got),     32'(exp));
    check({nm, "_stable"},  32'(stable),  32'd1);
    check({nm, "_done_at"}, 32'(done_at), 32'(last));
    check({nm, "_rdy_low"}, 32'(rdy_bad), 32'd0);
  endtask

  initial begin
    logic [11:0] got2;
    int d1, d2, gap, run, lows, dones;
    logic prev;

    // frames LSB first: start, data, [parity], stop(s)
    vecs[0] = '{0, 8'hA5, 12, 12'hD4A};
    vecs[1] = '{0, 8'h01, 12, 12'hE02};
    vecs[2] = '{0, 8'h00, 12, 12'hC00};
    vecs[3] = '{0, 8'hFF, 12, 12'hDFE};
    vecs[4] = '{0, 8'h80, 12, 12'hF00};
    vecs[5] = '{0, 8'h7F, 12, 12'hEFE};
    vecs[6] = '{0, 8'h3C, 12, 12'hC78};
    vecs[7] = '{1, 8'hC3, 10, 12'h386};
    vecs[8] = '{1, 8'h5A, 10, 12'h2B4};

    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);

    // reset state
    #23;
    check("rst_line_a",  32'(a_if.dataOut), 32'd1);
    check("rst_done_a",  32'(a_if.TXdone),  32'd0);
    check("rst_ready_a", 32'(a_if.TXready), 32'd0);
    check("rst_line_b",  32'(b_if.dataOut), 32'd1);
    @(negedge clk); rst = 1'b0;
    #1 check("rst_ready_still_low", 32'(a_if.TXready), 32'd0);
    @(negedge clk);
    check("rst_ready_next_cycle", 32'(a_if.TXready), 32'd1);

    for (int k = 0; k < 9; k++)
      send_frame(vecs[k].sel, vecs[k].data, vecs[k].nbits, vecs[k].frame,
                 $sformatf("vec%0d", k));

    // TXvalid held high: 0x00 then 0xFF back to back
    wait_ready(0, "b2b");
    drive(0, 1'b1, 8'h00);
    @(posedge clk); #1;
    a_if.TXin = 8'hFF;
    d1 = -1; d2 = -1; gap = -1; run = 0; prev = 1'b0; got2 = '0;
    for (int i = 0; i <= 1210; i++) begin
      @(negedge clk);
      if (i == 650) a_if.TXvalid = 1'b0;
      if (a_if.TXdone) begin
        if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i;
      end
      if (a_if.dataOut) run++;
      else begin
        if (prev && gap < 0) gap = run;
        run = 0;
      end
      prev = a_if.dataOut;
      if (i >= 601 && i < 1201 && (i - 601) % 50 == 25) got2[(i - 601) / 50] = a_if.dataOut;
    end
    check("b2b_done1", 32'(d1), 32'd600);
    check("b2b_done2", 32'(d2), 32'd1201);
    check("b2b_gap",   32'(gap), 32'd101);
    check("b2b_frame2", 32'(got2), 32'hDFE);

    // reset at cycle 230 of a frame
    wait_ready(0, "midrst");
    drive(0, 1'b1, 8'h3C);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h3C);
    repeat (230) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_line",  32'(a_if.dataOut), 32'd1);
    check("midrst_ready", 32'(a_if.TXready), 32'd0);
    check("midrst_done",  32'(a_if.TXdone),  32'd0);
    @(negedge clk); rst = 1'b0;
    lows = 0; dones = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (!a_if.dataOut) lows++;
      if (a_if.TXdone) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check("midrst_line_idle", 32'(lows), 32'd0);
    send_frame(0, 8'h3C, 12, 12'hC78, "midrst_resend");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
